dsp38_mac_sequencer: RTL and testbench

- Sequences one DSP38 configured for MULTIPLY_ACCUMULATE with input and output registers enabled.
- Accepts a job descriptor (length plus output controls), streams operand pairs in through a valid/ready handshake, and drives the DSP38 A/B and control pins cycle by cycle.
- Waits out the DSP pipeline, then returns the accumulated Z through a valid/ready result port.
- Sits between fabric logic and the I_BUF/DSP38/O_BUFT boundary of DSP test designs.

---
 rtl/dsp38_mac_sequencer_pkg.sv | 33 +++
 rtl/dsp38_mac_sequencer_if.sv | 62 ++++++
 rtl/dsp38_mac_sequencer_cfg_reg.sv | 30 +++
 rtl/dsp38_mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_dsp38_mac_sequencer.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsp38_mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Package : dsp38_seq_pkg
// Brief   : Shared types and constants for the DSP38 MAC sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package dsp38_seq_pkg;

    localparam int A_W = 20;
    localparam int B_W = 18;
    localparam int Z_W = 38;

    localparam logic [2:0] FB_ZERO = 3'b001;
    localparam logic [2:0] FB_ACC  = 3'b000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0] shift;
        logic       round;
        logic       saturate;
        logic       subtract;
        logic       unsigned_a;
        logic       unsigned_b;
    } job_cfg_t;

endpackage
`default_nettype wire

// File: rtl/dsp38_mac_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : dsp38_mac_sequencer_if
// Brief     : Job, operand, DSP38 pin and result bundle of the MAC sequencer.
// Rev       : 1.0  initial release
// ============================================================================
interface dsp38_mac_sequencer_if #(
    parameter int LEN_W = 8
);
    import dsp38_seq_pkg::*;

    logic             start;
    logic [LEN_W-1:0] cfg_len;
    logic [5:0]       cfg_shift;
    logic             cfg_round;
    logic             cfg_saturate;
    logic             cfg_subtract;
    logic             cfg_unsigned_a;
    logic             cfg_unsigned_b;
    logic             busy;
    logic             cfg_err;

    logic [A_W-1:0]   op_a;
    logic [B_W-1:0]   op_b;
    logic             op_valid;
    logic             op_ready;

    logic [A_W-1:0]   dsp_a;
    logic [B_W-1:0]   dsp_b;
    logic             dsp_load_acc;
    logic [2:0]       dsp_feedback;
    logic [5:0]       dsp_shift_right;
    logic             dsp_round;
    logic             dsp_saturate;
    logic             dsp_subtract;
    logic             dsp_unsigned_a;
    logic             dsp_unsigned_b;
    logic             dsp_reset;
    logic [Z_W-1:0]   dsp_z;

    logic [Z_W-1:0]   res_data;
    logic             res_valid;
    logic             res_ready;

    modport master (
        output start, cfg_len, cfg_shift, cfg_round, cfg_saturate, cfg_subtract,
               cfg_unsigned_a, cfg_unsigned_b, op_a, op_b, op_valid, dsp_z, res_ready,
        input  busy, cfg_err, op_ready, dsp_a, dsp_b, dsp_load_acc, dsp_feedback,
               dsp_shift_right, dsp_round, dsp_saturate, dsp_subtract,
               dsp_unsigned_a, dsp_unsigned_b, dsp_reset, res_data, res_valid
    );

    modport slave (
        input  start, cfg_len, cfg_shift, cfg_round, cfg_saturate, cfg_subtract,
               cfg_unsigned_a, cfg_unsigned_b, op_a, op_b, op_valid, dsp_z, res_ready,
        output busy, cfg_err, op_ready, dsp_a, dsp_b, dsp_load_acc, dsp_feedback,
               dsp_shift_right, dsp_round, dsp_saturate, dsp_subtract,
               dsp_unsigned_a, dsp_unsigned_b, dsp_reset, res_data, res_valid
    );

endinterface
`default_nettype wire

// File: rtl/dsp38_mac_sequencer_cfg_reg.sv
`default_nettype none
// ============================================================================
// Module : dsp38_seq_cfg_reg
// Brief  : Holds the accepted job configuration on the static DSP38 pins.
// Rev    : 1.0  initial release
// ============================================================================
module dsp38_seq_cfg_reg
    import dsp38_seq_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     i_load,
    input  wire job_cfg_t i_cfg,
    output job_cfg_t      o_cfg
);

    job_cfg_t r_cfg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg <= '0;
        end else if (i_load) begin
            r_cfg <= i_cfg;
        end
    end

    assign o_cfg = r_cfg;

endmodule
`default_nettype wire

// File: rtl/dsp38_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module : dsp38_mac_sequencer
// Brief  : Feeds one DSP38 MAC job and returns the accumulated Z.
// Rev    : 1.0  initial release
// ============================================================================
module dsp38_mac_sequencer
    import dsp38_seq_pkg::*;
#(
    parameter int LEN_W       = 8,
    parameter int DSP_LATENCY = 2
) (
    input wire logic             CLK,
    input wire logic             RESET,
    dsp38_mac_sequencer_if.slave bus
);

    localparam int c_DCNT_W = $clog2(DSP_LATENCY + 1);

    state_t              r_state;
    logic [LEN_W-1:0]    r_cnt;
    logic [c_DCNT_W-1:0] r_dcnt;
    logic                r_first;
    logic                r_busy;
    logic                r_op_ready;
    logic                r_cfg_err;
    logic [A_W-1:0]      r_dsp_a;
    logic [B_W-1:0]      r_dsp_b;
    logic                r_load_acc;
    logic [2:0]          r_feedback;
    logic                r_rst_d1;
    logic                r_dsp_reset;
    logic [Z_W-1:0]      r_res_data;
    logic                r_res_valid;

    logic                w_start_ok;
    job_cfg_t            w_cfg_in;
    job_cfg_t            w_cfg_q;

    assign w_start_ok = (r_state == IDLE) && bus.start && (bus.cfg_len != '0);
    assign w_cfg_in   = {bus.cfg_shift, bus.cfg_round, bus.cfg_saturate,
                         bus.cfg_subtract, bus.cfg_unsigned_a, bus.cfg_unsigned_b};

    dsp38_seq_cfg_reg u_cfg_reg (
        .clk    (CLK),
        .rst    (RESET),
        .i_load (w_start_ok),
        .i_cfg  (w_cfg_in),
        .o_cfg  (w_cfg_q)
    );

    always_ff @(posedge CLK) begin
        // DSP reset is stretched one cycle beyond the fabric reset.
        r_rst_d1    <= RESET;
        r_dsp_reset <= RESET | r_rst_d1;
        if (RESET) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dcnt      <= '0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_op_ready  <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_dsp_a     <= '0;
            r_dsp_b     <= '0;
            r_load_acc  <= 1'b0;
            r_feedback  <= FB_ACC;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_cfg_err  <= 1'b0;
            r_load_acc <= 1'b0;
            r_dsp_a    <= '0;
            r_dsp_b    <= '0;
            r_feedback <= FB_ACC;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.cfg_len == '0) begin
                            r_cfg_err <= 1'b1;
                        end else begin
                            r_cnt      <= bus.cfg_len;
                            r_first    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_op_ready <= 1'b1;
                            r_state    <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (bus.op_valid) begin
                        r_dsp_a    <= bus.op_a;
                        r_dsp_b    <= bus.op_b;
                        r_load_acc <= 1'b1;
                        r_feedback <= r_first ? FB_ZERO : FB_ACC;
                        r_first    <= 1'b0;
                        r_cnt      <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_op_ready <= 1'b0;
                            r_dcnt     <= c_DCNT_W'(DSP_LATENCY);
                            r_state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Pin register plus the DSP's two internal stages before Z settles.
                    if (r_dcnt == '0) begin
                        r_res_data  <= bus.dsp_z;
                        r_res_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_dcnt <= r_dcnt - c_DCNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy            = r_busy;
    assign bus.cfg_err         = r_cfg_err;
    assign bus.op_ready        = r_op_ready;
    assign bus.dsp_a           = r_dsp_a;
    assign bus.dsp_b           = r_dsp_b;
    assign bus.dsp_load_acc    = r_load_acc;
    assign bus.dsp_feedback    = r_feedback;
    assign bus.dsp_shift_right = w_cfg_q.shift;
    assign bus.dsp_round       = w_cfg_q.round;
    assign bus.dsp_saturate    = w_cfg_q.saturate;
    assign bus.dsp_subtract    = w_cfg_q.subtract;
    assign bus.dsp_unsigned_a  = w_cfg_q.unsigned_a;
    assign bus.dsp_unsigned_b  = w_cfg_q.unsigned_b;
    assign bus.dsp_reset       = r_dsp_reset;
    assign bus.res_data        = r_res_data;
    assign bus.res_valid       = r_res_valid;

endmodule
`default_nettype wire

// File: tb/tb_dsp38_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_dsp38_mac_sequencer
// Brief  : Directed bench for the DSP38 MAC sequencer with a behavioural DSP38.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dsp38_mac_sequencer;
    import dsp38_seq_pkg::*;

    logic CLK;
    logic RESET;
    int   n_vec;
    int   n_err;
    int   hi;

    dsp38_mac_sequencer_if #(.LEN_W(8)) bus ();

    dsp38_mac_sequencer #(.LEN_W(8), .DSP_LATENCY(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // DSP38 MAC with input and output registers; shift/round/saturate left at 0 where results are checked
    logic [A_W-1:0] m_a;
    logic [B_W-1:0] m_b;
    logic           m_load, m_sub, m_ua, m_ub;
    logic [2:0]     m_fb;
    logic [Z_W-1:0] m_z;

    function automatic logic [Z_W-1:0] mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                                           input logic ua, input logic ub);
        logic [Z_W-1:0] ea, eb;
        ea = ua ? {18'b0, a} : {{18{a[A_W-1]}}, a};
        eb = ub ? {20'b0, b} : {{20{b[B_W-1]}}, b};
        return ea * eb;
    endfunction

    always @(posedge CLK) begin
        if (bus.dsp_reset) begin
            m_a <= '0; m_b <= '0; m_load <= 1'b0; m_sub <= 1'b0;
            m_ua <= 1'b0; m_ub <= 1'b0; m_fb <= 3'b000; m_z <= '0;
        end else begin
            m_a <= bus.dsp_a; m_b <= bus.dsp_b; m_load <= bus.dsp_load_acc;
            m_sub <= bus.dsp_subtract; m_ua <= bus.dsp_unsigned_a;
            m_ub <= bus.dsp_unsigned_b; m_fb <= bus.dsp_feedback;
            if (m_load) begin
                if (m_sub) m_z <= ((m_fb == FB_ZERO) ? '0 : m_z) - mul(m_a, m_b, m_ua, m_ub);
                else       m_z <= ((m_fb == FB_ZERO) ? '0 : m_z) + mul(m_a, m_b, m_ua, m_ub);
            end
        end
    end
    assign bus.dsp_z = m_z;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        bus.op_a = a; bus.op_b = b; bus.op_valid = 1'b1;
        tick();
    endtask

    task automatic gap();
        bus.op_valid = 1'b0; bus.op_a = '0; bus.op_b = '0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_vec = 0; n_err = 0;
        RESET = 1'b1;
        bus.start = 1'b0; bus.cfg_len = '0; bus.cfg_shift = '0; bus.cfg_round = 1'b0;
        bus.cfg_saturate = 1'b0; bus.cfg_subtract = 1'b0; bus.cfg_unsigned_a = 1'b0;
        bus.cfg_unsigned_b = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_valid = 1'b0;
        bus.res_ready = 1'b0;

        // Power-on reset
        repeat (3) tick();
        chk("rst_busy",      64'(bus.busy), 64'd0);
        chk("rst_op_ready",  64'(bus.op_ready), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rst_cfg_err",   64'(bus.cfg_err), 64'd0);
        chk("rst_dsp_reset", 64'(bus.dsp_reset), 64'd1);
        chk("rst_load_acc",  64'(bus.dsp_load_acc), 64'd0);
        chk("rst_dsp_a",     64'(bus.dsp_a), 64'd0);
        chk("rst_shift",     64'(bus.dsp_shift_right), 64'd0);
        RESET = 1'b0;
        tick();
        chk("rst_tail_dsp_reset", 64'(bus.dsp_reset), 64'd1);
        tick();
        chk("rst_rel_dsp_reset", 64'(bus.dsp_reset), 64'd0);

        // Illegal length
        bus.start = 1'b1; bus.cfg_len = 8'd0;
        tick();
        chk("len0_cfg_err",  64'(bus.cfg_err), 64'd1);
        chk("len0_busy",     64'(bus.busy), 64'd0);
        chk("len0_op_ready", 64'(bus.op_ready), 64'd0);
        bus.start = 1'b0;
        tick();
        chk("len0_err_pulse", 64'(bus.cfg_err), 64'd0);
        chk("len0_idle_busy", 64'(bus.busy), 64'd0);

        // Basic job: 2*3 + 4*5 + (-1)*7 = 19
        bus.cfg_len = 8'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("basic_busy",     64'(bus.busy), 64'd1);
        chk("basic_op_ready", 64'(bus.op_ready), 64'd1);
        beat(20'd2, 18'd3);
        chk("basic_a0",  64'(bus.dsp_a), 64'd2);
        chk("basic_b0",  64'(bus.dsp_b), 64'd3);
        chk("basic_ld0", 64'(bus.dsp_load_acc), 64'd1);
        chk("basic_fb0", 64'(bus.dsp_feedback), 64'(3'b001));
        beat(20'd4, 18'd5);
        chk("basic_a1",  64'(bus.dsp_a), 64'd4);
        chk("basic_fb1", 64'(bus.dsp_feedback), 64'(3'b000));
        beat(20'hFFFFF, 18'd7);
        chk("basic_a2",       64'(bus.dsp_a), 64'hFFFFF);
        chk("basic_fb2",      64'(bus.dsp_feedback), 64'(3'b000));
        chk("basic_rdy_drop", 64'(bus.op_ready), 64'd0);
        bus.op_valid = 1'b0;
        bus.start = 1'b1; bus.cfg_len = 8'd5;
        tick();
        chk("drain_res_valid1", 64'(bus.res_valid), 64'd0);
        chk("drain_load_acc",   64'(bus.dsp_load_acc), 64'd0);
        chk("drain_cfg_err",    64'(bus.cfg_err), 64'd0);
        chk("drain_busy",       64'(bus.busy), 64'd1);
        tick();
        chk("drain_res_valid2", 64'(bus.res_valid), 64'd0);
        tick();
        chk("basic_res_valid", 64'(bus.res_valid), 64'd1);
        chk("basic_res_data",  64'(bus.res_data), 64'd19);

        // Back-pressure with start pulses that must be ignored
        for (int i = 0; i < 10; i++) begin
            bus.start = (i % 2 == 0);
            tick();
            chk("bp_res_valid", 64'(bus.res_valid), 64'd1);
            chk("bp_res_data",  64'(bus.res_data), 64'd19);
            chk("bp_op_ready",  64'(bus.op_ready), 64'd0);
            chk("bp_cfg_err",   64'(bus.cfg_err), 64'd0);
        end
        bus.start = 1'b0; bus.res_ready = 1'b1;
        tick();
        chk("bp_handshake_valid", 64'(bus.res_valid), 64'd0);
        chk("bp_handshake_busy",  64'(bus.busy), 64'd0);
        bus.res_ready = 1'b0;

        // Bubbles: 3*-2 + -5*-6 + 100*7 + 1*1 = 725
        bus.cfg_len = 8'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        beat(20'd3, 18'h3FFFE);
        chk("bub_ld0", 64'(bus.dsp_load_acc), 64'd1);
        chk("bub_fb0", 64'(bus.dsp_feedback), 64'(3'b001));
        gap();
        chk("bub_gap0_ld", 64'(bus.dsp_load_acc), 64'd0);
        chk("bub_gap0_a",  64'(bus.dsp_a), 64'd0);
        chk("bub_gap0_b",  64'(bus.dsp_b), 64'd0);
        chk("bub_gap0_rdy", 64'(bus.op_ready), 64'd1);
        beat(20'hFFFFB, 18'h3FFFA);
        chk("bub_ld1", 64'(bus.dsp_load_acc), 64'd1);
        chk("bub_fb1", 64'(bus.dsp_feedback), 64'(3'b000));
        gap();
        chk("bub_gap1_ld", 64'(bus.dsp_load_acc), 64'd0);
        beat(20'd100, 18'd7);
        chk("bub_ld2", 64'(bus.dsp_load_acc), 64'd1);
        gap();
        chk("bub_gap2_ld",  64'(bus.dsp_load_acc), 64'd0);
        chk("bub_gap2_rdy", 64'(bus.op_ready), 64'd1);
        beat(20'd1, 18'd1);
        chk("bub_ld3",      64'(bus.dsp_load_acc), 64'd1);
        chk("bub_rdy_done", 64'(bus.op_ready), 64'd0);
        bus.op_valid = 1'b0; bus.res_ready = 1'b1;
        tick(); tick();
        chk("bub_early_valid", 64'(bus.res_valid), 64'd0);
        tick();
        chk("bub_res_valid", 64'(bus.res_valid), 64'd1);
        chk("bub_res_data",  64'(bus.res_data), 64'd725);
        tick();
        chk("bub_same_cycle_hs", 64'(bus.res_valid), 64'd0);
        chk("bub_idle_busy",     64'(bus.busy), 64'd0);

        // Control passthrough, then back-to-back job with new configuration
        bus.cfg_shift = 6'd5; bus.cfg_round = 1'b1; bus.cfg_saturate = 1'b1;
        bus.cfg_unsigned_a = 1'b1; bus.cfg_subtract = 1'b0; bus.cfg_unsigned_b = 1'b0;
        bus.cfg_len = 8'd2; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.cfg_shift = 6'd9; bus.cfg_round = 1'b0; bus.cfg_saturate = 1'b0;
        bus.cfg_unsigned_a = 1'b0;
        chk("pt_shift", 64'(bus.dsp_shift_right), 64'd5);
        chk("pt_round", 64'(bus.dsp_round), 64'd1);
        chk("pt_sat",   64'(bus.dsp_saturate), 64'd1);
        chk("pt_ua",    64'(bus.dsp_unsigned_a), 64'd1);
        chk("pt_sub",   64'(bus.dsp_subtract), 64'd0);
        beat(20'd1, 18'd1);
        beat(20'd1, 18'd1);
        bus.op_valid = 1'b0;
        chk("pt_hold_shift", 64'(bus.dsp_shift_right), 64'd5);
        chk("pt_hold_round", 64'(bus.dsp_round), 64'd1);
        chk("pt_hold_sat",   64'(bus.dsp_saturate), 64'd1);
        chk("pt_hold_ua",    64'(bus.dsp_unsigned_a), 64'd1);
        repeat (3) tick();
        chk("pt_res_valid", 64'(bus.res_valid), 64'd1);
        bus.cfg_shift = 6'd0; bus.cfg_round = 1'b0; bus.cfg_saturate = 1'b0;
        bus.cfg_subtract = 1'b1; bus.cfg_unsigned_a = 1'b0; bus.cfg_unsigned_b = 1'b1;
        bus.cfg_len = 8'd1;
        tick();
        chk("pt_idle_busy",    64'(bus.busy), 64'd0);
        chk("pt_idle_shift",   64'(bus.dsp_shift_right), 64'd5);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("b2b_shift", 64'(bus.dsp_shift_right), 64'd0);
        chk("b2b_round", 64'(bus.dsp_round), 64'd0);
        chk("b2b_sat",   64'(bus.dsp_saturate), 64'd0);
        chk("b2b_sub",   64'(bus.dsp_subtract), 64'd1);
        chk("b2b_ua",    64'(bus.dsp_unsigned_a), 64'd0);
        chk("b2b_ub",    64'(bus.dsp_unsigned_b), 64'd1);
        beat(20'd3, 18'd4);
        bus.op_valid = 1'b0;
        chk("b2b_fb", 64'(bus.dsp_feedback), 64'(3'b001));
        repeat (3) tick();
        chk("b2b_res_valid", 64'(bus.res_valid), 64'd1);
        chk("b2b_res_data",  64'(bus.res_data), 64'h3F_FFFF_FFF4);
        tick();
        chk("b2b_hs", 64'(bus.res_valid), 64'd0);
        bus.res_ready = 1'b0;

        // Reset in the middle of an accumulation
        bus.cfg_subtract = 1'b0; bus.cfg_unsigned_b = 1'b0;
        bus.cfg_len = 8'd4; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        beat(20'd5, 18'd5);
        RESET = 1'b1;
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.dsp_reset === 1'b1) hi++;
            chk("mrst_busy",     64'(bus.busy), 64'd0);
            chk("mrst_op_ready", 64'(bus.op_ready), 64'd0);
            chk("mrst_load_acc", 64'(bus.dsp_load_acc), 64'd0);
        end
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.dsp_reset === 1'b1) hi++;
            chk("mrst_res_valid", 64'(bus.res_valid), 64'd0);
            chk("mrst_idle_busy", 64'(bus.busy), 64'd0);
            chk("mrst_idle_rdy",  64'(bus.op_ready), 64'd0);
        end
        chk("mrst_dsp_reset_cycles", 64'(hi), 64'd4);
        bus.op_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
